// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared direction codes, state encoding and mask search helpers
package elevator_pkg;

  // Direction codes as seen on the dir output
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;
  localparam logic [1:0] DIR_HOLD = 2'd3;

  // Widest building supported; masks are zero-extended to this width for searching
  localparam int MAX_FLOORS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  // True when any bit strictly above idx is set
  function automatic logic any_above(input logic [MAX_FLOORS-1:0] mask, input logic [3:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if ((i > int'(idx)) && mask[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  // True when any bit strictly below idx is set
  function automatic logic any_below(input logic [MAX_FLOORS-1:0] mask, input logic [3:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if ((i < int'(idx)) && mask[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/elevator_scan_ctrl_tick_timer.sv
// rtl/elevator_scan_ctrl_tick_timer.sv - free-running period counter with clear, enable and terminal flag
module tick_timer #(
  parameter int MAX_COUNT = 4,
  localparam int CNT_W = $clog2(MAX_COUNT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [CNT_W-1:0] r_count;

  // done marks the last cycle of a period; the count wraps to zero on it
  assign done = en && (r_count == CNT_W'(MAX_COUNT - 1));

  // Count enabled cycles; clear has priority so a restart always begins a full period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr || done) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - N-floor collective (SCAN) elevator car controller
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = 4,
  parameter int TICKS_PER_FLOOR = 50_000_000,
  parameter int DOOR_TICKS      = 100_000_000,
  localparam int FLOOR_W        = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req_car,
  input  logic [NUM_FLOORS-1:0] req_hall,
  output logic [FLOOR_W-1:0]    floor,
  output logic [1:0]            dir,
  output logic                  busy,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FLOOR_W-1:0]    r_floor;
  logic [FLOOR_W-1:0]    w_floor_nxt;
  logic [1:0]            r_dir;
  logic [1:0]            w_dir_nxt;
  logic [1:0]            r_last_dir;
  logic [1:0]            w_last_dir_nxt;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] w_pending_nxt;
  logic                  r_door_open;
  logic                  r_busy;

  logic [NUM_FLOORS-1:0] w_req;
  logic [NUM_FLOORS-1:0] w_cur_onehot;
  logic [NUM_FLOORS-1:0] w_clear;
  logic [NUM_FLOORS-1:0] w_latch_block;
  logic                  w_here_req;
  logic                  w_above;
  logic                  w_below;
  logic [1:0]            w_pick_dir;
  logic [FLOOR_W-1:0]    w_step_floor;
  logic                  w_step_hit;
  logic                  w_above_nf;
  logic                  w_below_nf;

  logic                  w_travel_en;
  logic                  w_travel_clr;
  logic                  w_travel_done;
  logic                  w_door_en;
  logic                  w_door_clr;
  logic                  w_door_done;

  assign w_req        = req_car | req_hall;
  assign w_cur_onehot = NUM_FLOORS'(1) << r_floor;
  assign w_here_req   = |(w_req & w_cur_onehot);

  // A press at the floor the car is parked at reopens the door instead of being queued
  assign w_latch_block = ((r_state == IDLE) || (r_state == DOOR)) ? w_cur_onehot : '0;

  assign w_above = any_above(MAX_FLOORS'(r_pending), 4'(r_floor));
  assign w_below = any_below(MAX_FLOORS'(r_pending), 4'(r_floor));

  // Floor the car reaches at the end of the current travel period
  assign w_step_floor = (r_dir == DIR_DOWN) ? (r_floor - FLOOR_W'(1)) : (r_floor + FLOOR_W'(1));
  assign w_step_hit   = r_pending[w_step_floor];
  assign w_above_nf   = any_above(MAX_FLOORS'(r_pending), 4'(w_step_floor));
  assign w_below_nf   = any_below(MAX_FLOORS'(r_pending), 4'(w_step_floor));

  assign w_travel_en  = (r_state == MOVE);
  assign w_travel_clr = (r_state != MOVE);
  assign w_door_en    = (r_state == DOOR);
  assign w_door_clr   = (r_state != DOOR) || w_here_req;

  tick_timer #(.MAX_COUNT(TICKS_PER_FLOOR)) u_travel_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_travel_clr),
    .en   (w_travel_en),
    .done (w_travel_done)
  );

  tick_timer #(.MAX_COUNT(DOOR_TICKS)) u_door_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_door_clr),
    .en   (w_door_en),
    .done (w_door_done)
  );

  // Departure direction from rest: tie goes to the direction last travelled
  always_comb begin
    w_pick_dir = DIR_HOLD;
    if (w_above && w_below) begin
      w_pick_dir = r_last_dir;
    end else if (w_above) begin
      w_pick_dir = DIR_UP;
    end else if (w_below) begin
      w_pick_dir = DIR_DOWN;
    end
  end

  // Next-state, floor, direction and request-clear decisions
  always_comb begin
    w_state_nxt    = r_state;
    w_floor_nxt    = r_floor;
    w_dir_nxt      = DIR_HOLD;
    w_last_dir_nxt = r_last_dir;
    w_clear        = '0;
    case (r_state)
      IDLE: begin
        if (r_pending[r_floor] || w_here_req) begin
          w_state_nxt = DOOR;
          w_clear     = w_cur_onehot;
        end else if (w_pick_dir != DIR_HOLD) begin
          w_state_nxt    = MOVE;
          w_dir_nxt      = w_pick_dir;
          w_last_dir_nxt = w_pick_dir;
        end
      end
      MOVE: begin
        w_dir_nxt = r_dir;
        if (w_travel_done) begin
          w_floor_nxt = w_step_floor;
          if (w_step_hit) begin
            w_state_nxt = DOOR;
            w_dir_nxt   = DIR_HOLD;
            w_clear     = NUM_FLOORS'(1) << w_step_floor;
          end else if ((r_dir == DIR_UP) ? w_above_nf : w_below_nf) begin
            w_state_nxt = MOVE;
          end else if ((r_dir == DIR_UP) ? w_below_nf : w_above_nf) begin
            w_dir_nxt      = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
            w_last_dir_nxt = w_dir_nxt;
          end else begin
            w_state_nxt = IDLE;
            w_dir_nxt   = DIR_HOLD;
          end
        end
      end
      DOOR: begin
        if (!w_here_req && w_door_done) begin
          if (w_pick_dir != DIR_HOLD) begin
            w_state_nxt    = MOVE;
            w_dir_nxt      = w_pick_dir;
            w_last_dir_nxt = w_pick_dir;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Requests accumulate until the car stops at their floor
  assign w_pending_nxt = (r_pending | (w_req & ~w_latch_block)) & ~w_clear;

  // FSM state, floor and direction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_floor    <= '0;
      r_dir      <= DIR_HOLD;
      r_last_dir <= DIR_UP;
    end else begin
      r_state    <= w_state_nxt;
      r_floor    <= w_floor_nxt;
      r_dir      <= w_dir_nxt;
      r_last_dir <= w_last_dir_nxt;
    end
  end

  // Request latch and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_door_open <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_pending   <= w_pending_nxt;
      r_door_open <= (w_state_nxt == DOOR);
      r_busy      <= (w_pending_nxt != '0) || (w_state_nxt == DOOR);
    end
  end

  assign floor     = r_floor;
  assign dir       = r_dir;
  assign busy      = r_busy;
  assign door_open = r_door_open;
  assign pending   = r_pending;

  // The car must never be commanded past either end of the shaft
  a_no_up_at_top: assert property (@(posedge clk) disable iff (!rst_n)
    !((r_dir == DIR_UP) && (r_floor == FLOOR_W'(NUM_FLOORS - 1))));
  a_no_down_at_ground: assert property (@(posedge clk) disable iff (!rst_n)
    !((r_dir == DIR_DOWN) && (r_floor == '0)));
  a_floor_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (r_floor <= FLOOR_W'(NUM_FLOORS - 1)));

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb/tb_elevator_scan_ctrl.sv - directed self-checking bench for elevator_scan_ctrl
module tb_elevator_scan_ctrl;

  localparam int NF = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] req_car = '0;
  logic [NF-1:0] req_hall = '0;
  logic [1:0]    floor;
  logic [1:0]    dir;
  logic          busy;
  logic          door_open;
  logic [NF-1:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  elevator_scan_ctrl #(
    .NUM_FLOORS     (NF),
    .TICKS_PER_FLOOR(4),
    .DOOR_TICKS     (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_car  (req_car),
    .req_hall (req_hall),
    .floor    (floor),
    .dir      (dir),
    .busy     (busy),
    .door_open(door_open),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] f, input logic [1:0] d,
                         input logic dr, input logic b, input logic [NF-1:0] p);
    chk({tag, ".floor"}, 32'(floor), 32'(f));
    chk({tag, ".dir"}, 32'(dir), 32'(d));
    chk({tag, ".door"}, 32'(door_open), 32'(dr));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".pending"}, 32'(pending), 32'(p));
  endtask

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nxt(1);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values, then 20 idle cycles
    nxt(1);
    chk_out("rst", 2'd0, 2'd3, 1'b0, 1'b0, 4'b0000);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nxt(1);
      chk_out("idle", 2'd0, 2'd3, 1'b0, 1'b0, 4'b0000);
    end

    // Single trip 0 -> 3
    req_car = 4'b1000;
    nxt(1); req_car = '0;
    chk_out("t2.n1", 2'd0, 2'd3, 1'b0, 1'b1, 4'b1000);
    nxt(1); chk_out("t2.n2", 2'd0, 2'd1, 1'b0, 1'b1, 4'b1000);
    nxt(3); chk("t2.n5.floor", 32'(floor), 32'd0);
    nxt(1); chk("t2.n6.floor", 32'(floor), 32'd1);
    nxt(3); chk("t2.n9.floor", 32'(floor), 32'd1);
    nxt(1); chk("t2.n10.floor", 32'(floor), 32'd2);
    nxt(4); chk_out("t2.n14", 2'd3, 2'd3, 1'b1, 1'b1, 4'b0000);
    nxt(2); chk("t2.n16.door", 32'(door_open), 32'd1);
    nxt(1); chk_out("t2.n17", 2'd3, 2'd3, 1'b0, 1'b0, 4'b0000);

    // Same-direction pickup at 2, then a hall call behind served after reversal
    do_reset();
    req_car = 4'b1000;
    nxt(1); req_car = '0;
    nxt(6); chk("t3.n7.floor", 32'(floor), 32'd1);
    req_hall = 4'b0100;
    nxt(1); req_hall = '0;
    chk("t3.n8.pending", 32'(pending), 32'b1100);
    nxt(2); chk_out("t3.n10", 2'd2, 2'd3, 1'b1, 1'b1, 4'b1000);
    nxt(2); chk("t3.n12.door", 32'(door_open), 32'd1);
    nxt(1); chk_out("t3.n13", 2'd2, 2'd1, 1'b0, 1'b1, 4'b1000);
    nxt(1); req_hall = 4'b0001;
    nxt(1); req_hall = '0;
    chk_out("t3.n15", 2'd2, 2'd1, 1'b0, 1'b1, 4'b1001);
    nxt(2); chk_out("t3.n17", 2'd3, 2'd3, 1'b1, 1'b1, 4'b0001);
    nxt(3); chk_out("t3.n20", 2'd3, 2'd2, 1'b0, 1'b1, 4'b0001);
    nxt(4); chk_out("t3.n24", 2'd2, 2'd2, 1'b0, 1'b1, 4'b0001);
    nxt(8); chk_out("t3.n32", 2'd0, 2'd3, 1'b1, 1'b1, 4'b0000);
    nxt(3); chk_out("t3.n35", 2'd0, 2'd3, 1'b0, 1'b0, 4'b0000);

    // Park at 1 after a downward move, then a tie between 3 and 0
    req_car = 4'b0100;
    nxt(1); req_car = '0;
    nxt(9); chk_out("t4.n10", 2'd2, 2'd3, 1'b1, 1'b1, 4'b0000);
    nxt(3); chk_out("t4.n13", 2'd2, 2'd3, 1'b0, 1'b0, 4'b0000);
    req_car = 4'b0010;
    nxt(1); req_car = '0;
    chk_out("t4.n14", 2'd2, 2'd3, 1'b0, 1'b1, 4'b0010);
    nxt(1); chk("t4.n15.dir", 32'(dir), 32'd2);
    nxt(4); chk_out("t4.n19", 2'd1, 2'd3, 1'b1, 1'b1, 4'b0000);
    nxt(3); chk_out("t4.n22", 2'd1, 2'd3, 1'b0, 1'b0, 4'b0000);
    req_car = 4'b1001;
    nxt(1); req_car = '0;
    chk_out("t4.n23", 2'd1, 2'd3, 1'b0, 1'b1, 4'b1001);
    nxt(1); chk_out("t4.n24", 2'd1, 2'd2, 1'b0, 1'b1, 4'b1001);
    nxt(4); chk_out("t4.n28", 2'd0, 2'd3, 1'b1, 1'b1, 4'b1000);
    nxt(3); chk_out("t4.n31", 2'd0, 2'd1, 1'b0, 1'b1, 4'b1000);
    nxt(12); chk_out("t4.n43", 2'd3, 2'd3, 1'b1, 1'b1, 4'b0000);
    nxt(3); chk_out("t4.n46", 2'd3, 2'd3, 1'b0, 1'b0, 4'b0000);

    // Door extend at floor 2 with a same-floor hall press on dwell cycle 2
    req_car = 4'b0100;
    nxt(1); req_car = '0;
    chk("t5.n1.pending", 32'(pending), 32'b0100);
    nxt(5); chk_out("t5.n6", 2'd2, 2'd3, 1'b1, 1'b1, 4'b0000);
    nxt(1); chk("t5.n7.door", 32'(door_open), 32'd1);
    req_hall = 4'b0100;
    nxt(1); req_hall = '0;
    chk_out("t5.n8", 2'd2, 2'd3, 1'b1, 1'b1, 4'b0000);
    nxt(1); chk_out("t5.n9", 2'd2, 2'd3, 1'b1, 1'b1, 4'b0000);
    nxt(1); chk_out("t5.n10", 2'd2, 2'd3, 1'b1, 1'b1, 4'b0000);
    nxt(1); chk_out("t5.n11", 2'd2, 2'd3, 1'b0, 1'b0, 4'b0000);

    // Asynchronous reset pulse between floors 1 and 2
    do_reset();
    req_car = 4'b1000;
    nxt(1); req_car = '0;
    nxt(6); chk_out("t6.pre", 2'd1, 2'd1, 1'b0, 1'b1, 4'b1000);
    #2 rst_n = 1'b0;
    req_car = 4'b0100;
    #1 chk_out("t6.low", 2'd0, 2'd3, 1'b0, 1'b0, 4'b0000);
    #1 rst_n = 1'b1;
    req_car = '0;
    chk_out("t6.rise", 2'd0, 2'd3, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      nxt(1);
      chk_out("t6.after", 2'd0, 2'd3, 1'b0, 1'b0, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
